// File: rtl/cim_pkg.sv
// cim_pkg: shared FSM encoding and width helpers for the bit-serial CIM MAC column.
package cim_pkg;

    // Controller states of the bit-serial MAC column.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cim_state_t;

    // Width of a $clog2-sized index, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Width of one reduced bit-plane: a weight plus the growth from summing ROWS terms.
    function automatic int ps_width(input int rows, input int weight_w);
        return weight_w + $clog2(rows + 1);
    endfunction

    // Width of the accumulated column result.
    function automatic int acc_width(input int rows, input int weight_w, input int input_w);
        return weight_w + input_w + $clog2(rows);
    endfunction

endpackage

// File: rtl/cim_plane_sum.sv
// cim_plane_sum: combinational reduction of one input bit-plane against the
// per-row weights. Each row contributes its weight when its input bit is set.
// With CIM_MAC_SIGNED_EN defined the weight MSB carries negative significance
// (two's-complement weights); otherwise weights are unsigned.
module cim_plane_sum
    import cim_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int WEIGHT_W = 4,
    localparam int PS_W    = ps_width(ROWS, WEIGHT_W)
) (
    input  logic [ROWS*WEIGHT_W-1:0] w,
    input  logic [ROWS-1:0]          rwlb,
    output logic [PS_W-1:0]          ps
);

    // Sum of (weight bit AND row input bit) << k over all rows and weight bits.
    always_comb begin
        ps = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < WEIGHT_W; k++) begin
                if (w[r*WEIGHT_W + k] & rwlb[r]) begin
`ifdef CIM_MAC_SIGNED_EN
                    // MSB of a two's-complement weight is worth -2^k.
                    if (k == WEIGHT_W - 1) begin
                        ps = ps - (PS_W'(1) << k);
                    end else begin
                        ps = ps + (PS_W'(1) << k);
                    end
`else
                    ps = ps + (PS_W'(1) << k);
`endif
                end
            end
        end
    end

endmodule

// File: rtl/cim_bitserial_mac.sv
// cim_bitserial_mac: bit-serial multiply-accumulate column. Weights are latched
// on start; input bit-planes arrive LSB first, each is reduced across rows by
// cim_plane_sum, registered, then shift-accumulated one cycle later.
// Optional feature macro: CIM_MAC_SIGNED_EN (two's-complement weights/inputs;
// the final plane is subtracted). Undefined: all operands unsigned.
//
// Handshake: start is taken on an edge where ready=1 (IDLE) and is ignored
// otherwise; wb is sampled on that same edge. In RUN, every edge with
// plane_valid=1 consumes one bit-plane from rwlb (there is no back-pressure,
// the block always accepts while in RUN); plane_valid is ignored in IDLE and
// DRAIN. done pulses for one cycle with result valid, and result holds until
// the next done.
module cim_bitserial_mac
    import cim_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int WEIGHT_W = 4,
    parameter int INPUT_W  = 4,
    localparam int ACC_W   = acc_width(ROWS, WEIGHT_W, INPUT_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWS*WEIGHT_W-1:0] wb,
    input  logic                     plane_valid,
    input  logic [ROWS-1:0]          rwlb,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         result,
    output cim_state_t               state_dbg
);

    localparam int PS_W  = ps_width(ROWS, WEIGHT_W);
    localparam int IDX_W = clog2_min1(INPUT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_W - 1);

    cim_state_t state_q, state_d;

    logic [ROWS*WEIGHT_W-1:0] w_q;
    logic [IDX_W-1:0]         idx_q;
    logic [PS_W-1:0]          ps_comb;
    logic [PS_W-1:0]          ps_q;
    logic [IDX_W-1:0]         sh_q;
    logic                     ps_v;
    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         acc_sum;
    logic [ACC_W-1:0]         ps_ext;
    logic [ACC_W-1:0]         ps_shift;
    logic [ACC_W-1:0]         result_q;
    logic                     done_q;
    logic                     accept_start;
    logic                     accept_plane;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign accept_plane = (state_q == ST_RUN) && plane_valid;

    cim_plane_sum #(
        .ROWS     (ROWS),
        .WEIGHT_W (WEIGHT_W)
    ) u_plane_sum (
        .w    (w_q),
        .rwlb (rwlb),
        .ps   (ps_comb)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> RUN on start, RUN -> DRAIN after the last plane, DRAIN -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (plane_valid && (idx_q == LAST_IDX)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight latch and plane index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q   <= '0;
            idx_q <= '0;
        end else if (accept_start) begin
            w_q   <= wb;
            idx_q <= '0;
        end else if (accept_plane) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Plane stage: register the reduced plane together with its bit position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
            sh_q <= '0;
            ps_v <= 1'b0;
        end else begin
            ps_v <= accept_plane;
            if (accept_plane) begin
                ps_q <= ps_comb;
                sh_q <= idx_q;
            end
        end
    end

    // Extend the registered plane to the result width, weight it by 2^sh_q and fold into acc.
    always_comb begin
`ifdef CIM_MAC_SIGNED_EN
        ps_ext   = ACC_W'($signed(ps_q));
        ps_shift = ps_ext << sh_q;
        // The input MSB plane has weight -2^(INPUT_W-1).
        if (sh_q == LAST_IDX) begin
            acc_sum = acc_q - ps_shift;
        end else begin
            acc_sum = acc_q + ps_shift;
        end
`else
        ps_ext   = ACC_W'(ps_q);
        ps_shift = ps_ext << sh_q;
        acc_sum  = acc_q + ps_shift;
`endif
    end

    // Accumulator: cleared on start, updated whenever a registered plane is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept_start) begin
            acc_q <= '0;
        end else if (ps_v) begin
            acc_q <= acc_sum;
        end
    end

    // Result capture in DRAIN, which always holds the final plane; done pulses one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DRAIN);
            if (state_q == ST_DRAIN) begin
                result_q <= acc_sum;
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = done_q;
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cim_bitserial_mac.sv
// tb_cim_bitserial_mac: self-checking bench for cim_bitserial_mac with
// ROWS=4, WEIGHT_W=4, INPUT_W=4. Expected results come from a dot-product
// model over whole integer operands; CIM_MAC_SIGNED_EN selects signed operands.
module tb_cim_bitserial_mac;
    import cim_pkg::*;

    localparam int ROWS     = 4;
    localparam int WEIGHT_W = 4;
    localparam int INPUT_W  = 4;
    localparam int ACC_W    = WEIGHT_W + INPUT_W + $clog2(ROWS);
    localparam int WB_W     = ROWS * WEIGHT_W;
    localparam int X_W      = ROWS * INPUT_W;

`ifdef CIM_MAC_SIGNED_EN
    localparam int EXP_FULL  = 4;     // (-1)*(-1) on each of 4 rows
    localparam int EXP_NEG1  = -28;   // (-1)*7 on each of 4 rows
`else
    localparam int EXP_FULL  = 900;   // 15*15 on each of 4 rows
    localparam int EXP_NEG1  = 420;   // 15*7 on each of 4 rows
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WB_W-1:0]  wb;
    logic             plane_valid;
    logic [ROWS-1:0]  rwlb;
    logic             ready;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
    cim_state_t       state_dbg;

    always #5 clk = ~clk;

    cim_bitserial_mac #(
        .ROWS     (ROWS),
        .WEIGHT_W (WEIGHT_W),
        .INPUT_W  (INPUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wb          (wb),
        .plane_valid (plane_valid),
        .rwlb        (rwlb),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] held = '0;
    logic             prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain dot product of per-row weight and input integers.
    function automatic int model(input logic [WB_W-1:0] w, input logic [X_W-1:0] x);
        int s;
        int wv;
        int xv;
        logic signed [WEIGHT_W-1:0] ws;
        logic signed [INPUT_W-1:0]  xs;
        logic [WEIGHT_W-1:0]        wu;
        logic [INPUT_W-1:0]         xu;
        s = 0;
        for (int r = 0; r < ROWS; r++) begin
            ws = w[r*WEIGHT_W +: WEIGHT_W];
            xs = x[r*INPUT_W +: INPUT_W];
            wu = w[r*WEIGHT_W +: WEIGHT_W];
            xu = x[r*INPUT_W +: INPUT_W];
`ifdef CIM_MAC_SIGNED_EN
            wv = int'(ws);
            xv = int'(xs);
`else
            wv = int'(wu);
            xv = int'(xu);
`endif
            s += wv * xv;
        end
        return s;
    endfunction

    // Compare process: every cycle out of reset, check done/result against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            chk("ready_vs_busy", {31'd0, ready ^ busy}, 32'd1);
            if (done) begin
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                chk("ready_at_done", {31'd0, ready}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("result", {22'd0, result}, {22'd0, exp_q.pop_front()});
                end
                held = result;
            end else begin
                chk("result_hold", {22'd0, result}, {22'd0, held});
            end
            prev_done = done;
        end
    end

    // ---------------- driver ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            plane_valid = 1'($urandom_range(0, 1));
            rwlb        = ROWS'($urandom);
            @(posedge clk); #1;
        end
        plane_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'd0, ready}, 32'd1);
        chk({tag, "_busy"},   {31'd0, busy},  32'd0);
        chk({tag, "_done"},   {31'd0, done},  32'd0);
        chk({tag, "_result"}, {22'd0, result}, 32'd0);
        chk({tag, "_state"},  {30'd0, state_dbg}, {30'd0, ST_IDLE});
    endtask

    // One operation: start, INPUT_W planes (optional stalls / start pokes / abort), wait for done.
    task automatic run_op(input logic [WB_W-1:0] w, input logic [X_W-1:0] x, input int expv,
                          input logic [INPUT_W-1:0] smask, input int slen,
                          input bit poke, input bit abort2);
        int edges;
        int guard;
        int stalls;
        guard = 0;
        while (!ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_start", {31'd0, ready}, 32'd1);
        start       = 1'b1;
        wb          = w;
        plane_valid = 1'($urandom_range(0, 1));
        rwlb        = ROWS'($urandom);
        exp_q.push_back(ACC_W'(expv));
        @(posedge clk); #1;
        start  = 1'b0;
        wb     = WB_W'($urandom);
        edges  = 1;
        stalls = 0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int p = 0; p < INPUT_W; p++) begin
            if (smask[p]) begin
                for (int s = 0; s < slen; s++) begin
                    plane_valid = 1'b0;
                    rwlb        = ROWS'($urandom);
                    if (poke) begin
                        start = 1'b1;
                        wb    = ~w;
                    end
                    @(posedge clk); #1;
                    start = 1'b0;
                    edges++;
                    stalls++;
                end
            end
            plane_valid = 1'b1;
            for (int r = 0; r < ROWS; r++) rwlb[r] = x[r*INPUT_W + p];
            if (poke && p == 1) begin
                start = 1'b1;
                wb    = ~w;
            end
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            if (abort2 && p == 1) begin
                rst = 1'b1;
                plane_valid = 1'b0;
                exp_q.delete();
                held = '0;
                #1;
                check_reset_outputs("abort");
                @(posedge clk); @(posedge clk); #1;
                check_reset_outputs("abort_hold");
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        // DRAIN cycle: plane_valid here must be ignored.
        plane_valid = 1'($urandom_range(0, 1));
        rwlb        = ROWS'($urandom);
        guard = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            guard++;
        end while (!done && guard < 40);
        plane_valid = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("latency", edges, INPUT_W + 2 + stalls);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WB_W-1:0]    rw;
        logic [X_W-1:0]     rx;
        logic [INPUT_W-1:0] rmask;

        rst = 1'b1;
        start = 1'b0;
        wb = '0;
        plane_valid = 1'b0;
        rwlb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model against hand-computed values.
        chk("model_full",  model(16'hFFFF, 16'hFFFF), EXP_FULL);
        chk("model_mixed", model(16'h4321, 16'h1234), 20);
        chk("model_ones",  model(16'h1111, 16'h1111), 4);
        chk("model_msb",   model(16'h0008, 16'h0008), 64);
        chk("model_neg",   model(16'hFFFF, 16'h7777), EXP_NEG1);

        // Full scale, then back-to-back start in the done cycle.
        run_op(16'hFFFF, 16'hFFFF, EXP_FULL, 4'b0000, 0, 1'b0, 1'b0);
        run_op(16'h1111, 16'h1111, 4, 4'b0000, 0, 1'b0, 1'b0);
        idle_cycles(2);

        // Mixed values, two planes stalled 3 cycles each.
        run_op(16'h4321, 16'h1234, 20, 4'b0110, 3, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(16'h4321, 16'h1234, 20, 4'b0000, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // Start pulsed during RUN with inverted weights must be ignored.
        run_op(16'h4321, 16'h1234, 20, 4'b0101, 2, 1'b1, 1'b0);
        idle_cycles(2);

        // Reset mid-RUN after two planes, then a clean operation.
        run_op(16'hFFFF, 16'hFFFF, EXP_FULL, 4'b0000, 0, 1'b0, 1'b1);
        run_op(16'h4321, 16'h1234, 20, 4'b0000, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // Sign-sensitive directed cases.
        run_op(16'h0008, 16'h0008, 64, 4'b0000, 0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h7777, EXP_NEG1, 4'b0000, 0, 1'b0, 1'b0);
        idle_cycles(1);

        // Randomized operations with random gaps, stalls and ignored starts.
        for (int n = 0; n < 40; n++) begin
            rw    = WB_W'($urandom);
            rx    = X_W'($urandom);
            rmask = INPUT_W'($urandom_range(0, 15));
            idle_cycles($urandom_range(0, 3));
            run_op(rw, rx, model(rw, rx), rmask, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        idle_cycles(4);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cim_bitserial_mac.md
# cim_bitserial_mac

Parametrised bit-serial multiply-accumulate column for the digital CIM array. It extends the single-bit weight×input product to multi-bit weights held per row. Input activations arrive as bit-planes, least-significant bit first. Each plane is reduced across all rows and shift-accumulated into one column result. The block sits between the row word-line driver, which supplies the input bit-planes, and the column readout / output buffer.

## Interface
Parameters:
- ROWS, 16: rows summed per column.
- WEIGHT_W, 4: weight bits per row.
- INPUT_W, 4: input bits, equal to the number of planes per operation.
- ACC_W (local), WEIGHT_W+INPUT_W+$clog2(ROWS): result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin an operation; accepted only when ready=1.
- wb  in  ROWS*WEIGHT_W  weights; row r occupies bits [r*WEIGHT_W +: WEIGHT_W]; sampled when start is accepted.
- plane_valid  in  1  an input bit-plane is present.
- rwlb  in  ROWS  input bit-plane; bit r belongs to row r.
- ready  out  1  idle and able to accept start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result is valid.
- result  out  ACC_W  column dot product; held until the next done.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - ready=1.
  - start=1 latches wb into w_q, clears acc and plane index idx, and moves to RUN.
- RUN:
  - On each edge with plane_valid=1, the block registers ps_q = Σ_r Σ_k (w_q[r][k] & rwlb[r]) << k, records sh_q=idx, and sets ps_v=1.
  - idx increments on each accepted plane.
  - After plane INPUT_W-1 is accepted, the FSM moves to DRAIN.
  - plane_valid=0 stalls the operation indefinitely; no timeout.
- Accumulate stage:
  - On each edge where ps_v=1, acc <= acc + (ps_q << sh_q).
- DRAIN:
  - The accumulate stage consumes the final ps_q.
  - result <= acc + (ps_q << sh_q), done <= 1, and the FSM returns to IDLE.
- busy is 1 in RUN and DRAIN. ready = (state==IDLE).
- start is ignored when ready=0. plane_valid is ignored outside RUN.
- Widths:
  - ps_q is WEIGHT_W+$clog2(ROWS+1) bits.
  - The shifted sum is extended to ACC_W before it is added.
  - Overflow cannot occur for the ACC_W defined above.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, acc=0, w_q=0, idx=0, ps_v=0.
- Reset asserted mid-operation discards all partial state. The block needs a fresh start afterwards.

## Timing
- start is accepted at edge S. RUN is in effect from the cycle after S.
- The earliest first plane is accepted at edge S+1.
- The last plane is accepted at edge T. done=1 and result is valid in the cycle after edge T+1.
- With no stalls, total latency from the start edge to done is INPUT_W+2 edges.
- ready rises in the same cycle done is high, so start may be re-accepted on that cycle's edge. This gives back-to-back operations with one idle-free turnaround.
- done is exactly one cycle long. result is stable until the next done.

## Configuration
- CIM_MAC_SIGNED_EN defined: two's-complement weights and inputs.
  - Weight bit k=WEIGHT_W-1 contributes a negative term, -(… << k).
  - The plane at idx=INPUT_W-1 is subtracted from acc rather than added.
  - ps_q and acc are signed and sign-extended.
  - result is signed in the range -ROWS·2^(WEIGHT_W+INPUT_W-2) … +ROWS·2^(WEIGHT_W+INPUT_W-2).
- CIM_MAC_SIGNED_EN undefined: all operands are unsigned, and every term is added.

## Structure
- Shared package cim_pkg holds:
  - the FSM state encoding (IDLE/RUN/DRAIN);
  - a width helper function for ACC_W and the ps_q width.
- One sub-module, cim_plane_sum:
  - combinational;
  - parameters ROWS and WEIGHT_W;
  - inputs w and rwlb, output ps;
  - contains the per-row AND products and the weighted adder tree, including the signed MSB-weight handling under the macro.

## Test plan
Parameters ROWS=4, WEIGHT_W=4, INPUT_W=4 unless stated.
- Unsigned full scale: all weights 15, all input values 15 (four planes of 4'b1111) -> result=900, done one cycle, latency 6 edges.
- Mixed values: weights {1,2,3,4}, inputs {4,3,2,1} -> result=20. Two planes stalled by plane_valid=0 for 3 cycles each -> same result, done delayed by 6 cycles.
- Back-to-back: start asserted in the done cycle with new weights all 1 and inputs all 1 -> second result=4, first result held until the second done.
- Reset mid-RUN after 2 planes -> ready=1, busy=0, result=0. The next full operation gives the correct value, with no residue.
- Start ignored: start pulsed during RUN with different wb -> the result reflects the original wb only.
- Signed, with CIM_MAC_SIGNED_EN: row0 weight -8, input -8, other rows 0 -> result=+64. All weights -1, all inputs 7 -> result=-28.
